// File: rtl/alu_interface_ctrl.sv
// alu_interface_ctrl: collects A, B and opcode words from a byte-serial source,
// drives a registered ALU, waits out its latency and offers the result
// downstream under a valid/ready handshake.
module alu_interface_ctrl #(
    parameter int unsigned N_DATA = 8,
    parameter int unsigned N_BITS = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_DATA-1:0] i_data,
    input  logic              i_valid,
    input  logic [N_BITS-1:0] i_alu_result,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_BITS-1:0] o_alu_op,
    output logic [N_DATA-1:0] o_result,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_error,
    output logic              o_busy,
    output logic [7:0]        o_op_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        CAPT   = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] alu_a_q, alu_a_d;
    logic [N_BITS-1:0] alu_b_q, alu_b_d;
    logic [N_BITS-1:0] alu_op_q, alu_op_d;
    logic [N_DATA-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [N_BITS-1:0] in_word_c;

    // Only the low N_BITS of each incoming word carry information
    assign in_word_c = i_data[N_BITS-1:0];

    generate
        if (N_DATA > N_BITS) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^i_data[N_DATA-1:N_BITS];
        end
    endgenerate

    // Opcodes the ALU implements; everything else is rejected without execution
    function automatic logic is_legal(input logic [N_BITS-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            N_BITS'(6'b100000), N_BITS'(6'b100010), N_BITS'(6'b100100),
            N_BITS'(6'b100101), N_BITS'(6'b100110), N_BITS'(6'b000011),
            N_BITS'(6'b000010), N_BITS'(6'b100111): ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= GET_A;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
            op_count_q     <= op_count_d;
        end
    end

    // Next-state and next-output logic; valid/busy follow the next state so they are registered
    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        result_d       = result_q;
        error_d        = error_q;
        op_count_d     = op_count_q;
        result_valid_d = 1'b0;
        busy_d         = 1'b0;

        case (state_q)
            GET_A: begin
                if (i_valid) begin
                    alu_a_d = in_word_c;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (i_valid) begin
                    alu_b_d = in_word_c;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (i_valid) begin
                    alu_op_d = in_word_c;
                    if (is_legal(in_word_c)) begin
                        state_d = EXEC;
                    end else begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = SEND;
                    end
                end
            end
            EXEC: begin
                state_d = CAPT;
            end
            CAPT: begin
                result_d = N_DATA'(i_alu_result);
                error_d  = 1'b0;
                state_d  = SEND;
            end
            SEND: begin
                if (i_result_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase

        result_valid_d = (state_d == SEND);
        busy_d         = (state_d != GET_A);
    end

    assign o_alu_a        = alu_a_q;
    assign o_alu_b        = alu_b_q;
    assign o_alu_op       = alu_op_q;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_error        = error_q;
    assign o_busy         = busy_q;
    assign o_op_count     = op_count_q;

endmodule

// File: tb/tb_alu_interface_ctrl.sv
// Testbench for alu_interface_ctrl: registered ALU stub plus a transaction-level
// reference model (expected result, latency, counter, held operands).
module tb_alu_interface_ctrl;

    localparam int unsigned N_DATA = 8;
    localparam int unsigned N_BITS = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [N_DATA-1:0] i_data;
    logic              i_valid;
    logic [N_BITS-1:0] i_alu_result;
    logic [N_BITS-1:0] o_alu_a, o_alu_b, o_alu_op;
    logic [N_DATA-1:0] o_result;
    logic              o_result_valid;
    logic              i_result_ready;
    logic              o_error;
    logic              o_busy;
    logic [7:0]        o_op_count;

    int total = 0;
    int bad   = 0;

    // Model state
    int         exp_count = 0;
    logic [5:0] exp_a = 6'h0, exp_b = 6'h0, exp_op = 6'h0;

    alu_interface_ctrl #(.N_DATA(N_DATA), .N_BITS(N_BITS)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_alu_result   (i_alu_result),
        .o_alu_a        (o_alu_a),
        .o_alu_b        (o_alu_b),
        .o_alu_op       (o_alu_op),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_error        (o_error),
        .o_busy         (o_busy),
        .o_op_count     (o_op_count)
    );

    always #5 clock = ~clock;

    // Reference arithmetic in plain integers, modulo 64
    function automatic int ref_result(input int a, input int b, input int op);
        case (op)
            32: return (a + b) % 64;
            34: return (a - b + 64) % 64;
            36: return a & b;
            37: return a | b;
            38: return a ^ b;
            3, 2: return (b >= 6) ? 0 : (a / (1 << b));
            39: return 63 - (a | b);
            default: return -1;
        endcase
    endfunction

    // ALU stub with one cycle of registered latency; illegal codes give a marker value
    logic [5:0] alu_r;
    always_ff @(posedge clock) begin
        if (ref_result(int'(o_alu_a), int'(o_alu_b), int'(o_alu_op)) < 0)
            alu_r <= 6'h2A;
        else
            alu_r <= 6'(ref_result(int'(o_alu_a), int'(o_alu_b), int'(o_alu_op)));
    end
    assign i_alu_result = alu_r;

    // One full transaction; starts and ends on a falling edge
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int hold, input bit noise, input string name);
        int         c;
        int         r;
        logic       legal;
        logic [7:0] er;
        logic       ee;
        r     = ref_result(int'(a[5:0]), int'(b[5:0]), int'(op[5:0]));
        legal = (r >= 0);
        er    = legal ? 8'(r) : 8'h00;
        ee    = !legal;

        i_data = a; i_valid = 1'b1; @(negedge clock);
        i_data = b; @(negedge clock);
        i_data = op; @(negedge clock);
        i_valid = 1'b0;
        exp_a = a[5:0]; exp_b = b[5:0]; exp_op = op[5:0];

        total++;
        if (o_busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_op got=%0b exp=1", name, o_busy);
        end

        c = 1;
        while (o_result_valid !== 1'b1 && c < 10) begin
            if (noise) begin i_valid = 1'b1; i_data = 8'($urandom); end
            @(negedge clock);
            i_valid = 1'b0;
            c++;
        end
        total++;
        if (c != (legal ? 3 : 1)) begin
            bad++; $display("FAIL %s latency got=%0d exp=%0d", name, c, legal ? 3 : 1);
        end
        total++;
        if (o_result !== er) begin
            bad++; $display("FAIL %s result got=%02h exp=%02h", name, o_result, er);
        end
        total++;
        if (o_error !== ee) begin
            bad++; $display("FAIL %s error got=%0b exp=%0b", name, o_error, ee);
        end
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op} !== {exp_a, exp_b, exp_op}) begin
            bad++; $display("FAIL %s alu_regs got=%02h/%02h/%02h exp=%02h/%02h/%02h",
                            name, o_alu_a, o_alu_b, o_alu_op, exp_a, exp_b, exp_op);
        end

        for (int h = 0; h < hold; h++) begin
            if (noise) begin i_valid = 1'b1; i_data = 8'h11; end
            @(negedge clock);
            i_valid = 1'b0;
            total++;
            if (o_result_valid !== 1'b1 || o_result !== er || o_error !== ee) begin
                bad++; $display("FAIL %s stall_stable got=%0b/%02h/%0b exp=1/%02h/%0b",
                                name, o_result_valid, o_result, o_error, er, ee);
            end
        end

        i_result_ready = 1'b1;
        if (noise) begin i_valid = 1'b1; i_data = 8'h11; end
        @(negedge clock);
        i_result_ready = 1'b0;
        i_valid = 1'b0;
        exp_count = (exp_count + 1) % 256;

        total++;
        if (o_result_valid !== 1'b0) begin
            bad++; $display("FAIL %s valid_after_xfer got=%0b exp=0", name, o_result_valid);
        end
        total++;
        if (o_op_count !== 8'(exp_count)) begin
            bad++; $display("FAIL %s op_count got=%0d exp=%0d", name, o_op_count, exp_count);
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_idle got=%0b exp=0", name, o_busy);
        end
        total++;
        if (o_result !== er || {o_alu_a, o_alu_b, o_alu_op} !== {exp_a, exp_b, exp_op}) begin
            bad++; $display("FAIL %s held_after_xfer got=%02h %02h/%02h/%02h exp=%02h %02h/%02h/%02h",
                            name, o_result, o_alu_a, o_alu_b, o_alu_op, er, exp_a, exp_b, exp_op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_result_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error, o_busy, o_op_count} !== '0) begin
            bad++; $display("FAIL reset_values got=%02h/%02h/%02h %02h %0b %0b %0b %0d exp=all zero",
                            o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error, o_busy, o_op_count);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle got=%0b/%0b exp=0/0", o_busy, o_result_valid);
        end
    endtask

    task automatic test_add();
        do_txn(8'h05, 8'h03, 8'h20, 0, 1'b0, "add");
    endtask

    task automatic test_sub_wrap();
        do_txn(8'h03, 8'h05, 8'h22, 0, 1'b0, "sub_wrap");
        do_txn(8'hC3, 8'h45, 8'hA2, 0, 1'b0, "sub_upper_bits");
    endtask

    task automatic test_back_to_back();
        do_txn(8'h30, 8'h04, 8'h03, 0, 1'b0, "b2b_shift");
        do_txn(8'h0F, 8'h30, 8'h27, 0, 1'b0, "b2b_nor");
    endtask

    task automatic test_illegal();
        do_txn(8'h01, 8'h02, 8'h3F, 0, 1'b0, "illegal_op");
        total++;
        if (o_alu_op !== 6'h3F) begin
            bad++; $display("FAIL illegal_alu_op got=%02h exp=3f", o_alu_op);
        end
    endtask

    task automatic test_backpressure();
        do_txn(8'h0A, 8'h07, 8'h24, 5, 1'b1, "backpressure");
        do_txn(8'h12, 8'h21, 8'h25, 0, 1'b0, "after_backpressure");
    endtask

    task automatic test_reset_mid();
        i_data = 8'h2B; i_valid = 1'b1; @(negedge clock);
        i_data = 8'h15; @(negedge clock);
        i_valid = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_alu_a !== 6'h2B || o_alu_b !== 6'h15) begin
            bad++; $display("FAIL partial_capture got=%0b %02h/%02h exp=1 2b/15", o_busy, o_alu_a, o_alu_b);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error, o_busy, o_op_count} !== '0) begin
            bad++; $display("FAIL async_reset got=%02h/%02h/%02h %02h %0b %0b %0b %0d exp=all zero",
                            o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error, o_busy, o_op_count);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_a = 6'h0; exp_b = 6'h0; exp_op = 6'h0; exp_count = 0;
        do_txn(8'h01, 8'h01, 8'h20, 0, 1'b0, "add_after_reset");
    endtask

    task automatic test_random();
        logic [7:0] legal_ops [8];
        logic [7:0] op;
        legal_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) op = 8'($urandom);
            else op = {2'($urandom), legal_ops[$urandom_range(7)][5:0]};
            do_txn(8'($urandom), 8'($urandom), op, int'($urandom_range(3)),
                   1'($urandom_range(1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
